// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: aligns stores into byte lanes, extracts/extends loads, req/ack memory port.
// Optional LSU_TIMEOUT_EN adds an ack-wait watchdog that ends the access as a fault.
module lsu_mem_ctrl
`ifdef LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYC = 16)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, FAULT = 2'd2, RESP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        flt_q, flt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = |a[1:0];
      default: is_misaligned = |a;
    endcase
  endfunction

  function automatic logic [7:0] lane_strb(input logic [1:0] sz, input logic [2:0] a);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    lane_strb = base << a;
  endfunction

  function automatic logic [63:0] lane_repl(input logic [1:0] sz, input logic [63:0] d);
    case (sz)
      2'b00:   lane_repl = {8{d[7:0]}};
      2'b01:   lane_repl = {4{d[15:0]}};
      2'b10:   lane_repl = {2{d[31:0]}};
      default: lane_repl = d;
    endcase
  endfunction

  function automatic logic [63:0] load_extract(input logic [1:0] sz, input logic u,
                                                input logic [2:0] a, input logic [63:0] d);
    logic [63:0] lane;
    lane = d >> {a, 3'b000};
    case (sz)
      2'b00:   load_extract = u ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'b01:   load_extract = u ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'b10:   load_extract = u ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_extract = lane;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    flt_d   = flt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr;
          wdata_d = wdata;
          flt_d   = is_misaligned(size, addr[2:0]);
          state_d = is_misaligned(size, addr[2:0]) ? FAULT : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = RESP;
          if (!we_q) rdata_d = load_extract(size_q, uns_q, addr_q[2:0], mem_rdata);
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          flt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      FAULT:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      flt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      flt_q   <= flt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Memory side is decoded from state so an async reset drops mem_req immediately.
  // Handshake: mem_req and its payload stay stable from ACCESS entry until the cycle mem_ack=1.
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[63:3], 3'b000};
  assign mem_wdata = lane_repl(size_q, wdata_q);
  assign mem_wstrb = mem_we ? lane_strb(size_q, addr_q[2:0]) : 8'h00;
  assign done      = (state_q == RESP);
  assign misalign  = done & flt_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases, reset mid-access, optional timeout, random traffic vs byte-level model.
module tb_lsu_mem_ctrl;

  logic        clk, rst, req, we, uns, mem_ack;
  logic [1:0]  size;
  logic [63:0] addr, wdata, mem_rdata;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic        done, misalign, busy, mem_req, mem_we;
  logic [7:0]  mem_wstrb;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_rdata = '0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .misalign(misalign),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // reference model: byte-lane view of the access
  function automatic bit m_mis(input int nb, input logic [63:0] a);
    return (a % nb) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input int nb, input int off);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + nb) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input int nb, input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input int nb, input logic u, input int off, input logic [63:0] m);
    logic [63:0] v, mask;
    v    = m >> (8 * off);
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (!u && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // driver: one complete access, checked cycle by cycle at the negedge
  task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] mr, input int dly, input logic hold_req);
    int nb;
    int off;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(negedge clk);
    if (!hold_req) req = 1'b0;
    if (m_mis(nb, a)) begin
      check("flt_busy", busy, 1);
      check("flt_mem_req", mem_req, 0);
      check("flt_done", done, 0);
      @(negedge clk);
      check("flt_resp_done", done, 1);
      check("flt_resp_misalign", misalign, 1);
      check("flt_resp_mem_req", mem_req, 0);
      check("flt_rdata_held", rdata, exp_rdata);
    end else begin
      if (!w) exp_q.push_back(m_load(nb, u, off, mr));
      for (int k = 0; k <= dly; k++) begin
        check("acc_mem_req", mem_req, 1);
        check("acc_busy", busy, 1);
        check("acc_done", done, 0);
        check("acc_mem_we", mem_we, w);
        if (k == 0) begin
          check("acc_mem_addr", mem_addr, {a[63:3], 3'b000});
          check("acc_wstrb", mem_wstrb, w ? m_strb(nb, off) : 8'h00);
          if (w) check("acc_wdata", mem_wdata, m_wdata(nb, wd));
        end
        mem_ack   = (k == dly);
        mem_rdata = (k == dly) ? mr : {$urandom, $urandom};
        @(negedge clk);
      end
      mem_ack = 1'b0;
      check("resp_done", done, 1);
      check("resp_misalign", misalign, 0);
      check("resp_busy", busy, 1);
      check("resp_mem_req", mem_req, 0);
      if (!w) exp_rdata = exp_q.pop_front();
      check("resp_rdata", rdata, exp_rdata);
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    req = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ack_ignored", busy, 0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_done", done, 0);
    check("rst_misalign", misalign, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    rst = 1'b1;

    do_access(1'b0, 2'b10, 1'b0, 64'h1004, 64'h0, 64'h80000000_00000000, 0, 1'b0);
    do_access(1'b1, 2'b00, 1'b0, 64'h2003, 64'hAB, 64'h0, 2, 1'b0);
    do_access(1'b0, 2'b01, 1'b0, 64'h3001, 64'h0, 64'h0, 0, 1'b0);
    do_access(1'b0, 2'b00, 1'b1, 64'h7, 64'h0, 64'hF0000000_00000000, 5, 1'b0);
    do_access(1'b0, 2'b11, 1'b0, 64'h4000, 64'h0, 64'h01234567_89ABCDEF, 1, 1'b1);

    // reset in the middle of an access
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 64'h5000;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rdata", rdata, 0);
    exp_rdata = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 2'b01, 1'b0, 64'h6002, 64'h0, 64'h0000_0000_8001_0000, 0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      int acc_cyc;
      acc_cyc = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b11; addr = 64'h8000;
      @(negedge clk);
      for (int k = 0; k < 40 && !done; k++) begin
        if (mem_req) acc_cyc++;
        @(negedge clk);
      end
      req = 1'b0;
      check("to_cycles", 64'(acc_cyc), 64'd16);
      check("to_done", done, 1);
      check("to_misalign", misalign, 1);
      check("to_mem_req", mem_req, 0);
      check("to_rdata_held", rdata, exp_rdata);
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("to_late_ack", busy, 0);
    end
`endif

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
